sm4_request_arbiter: RTL

- Shares one sm4_encryptor core between num_req_p independent requesters.
- Round-robin grant; one transaction in flight at a time.
- Latches the winner's content/key/mode, drives the core's v_i/ready_o input handshake, consumes the core's v_o/yumi_i output, and returns the result to the granted requester only.
- Sits between client ports and the core inside the encryptor subsystem.

---
 rtl/sm4_encryptor_pkg.sv | 15 +
 rtl/sm4_rr_picker.sv | 33 +++
 rtl/sm4_request_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sm4_encryptor_pkg.sv
// Shared types and widths for the SM4 encryptor subsystem.
package sm4_encryptor_pkg;

  localparam int sm4_block_width_gp = 128;
  localparam int sm4_key_width_gp   = 128;
  localparam int sm4_stat_width_gp  = 16;

  typedef enum logic [1:0] {
    eArbIdle,
    eArbIssue,
    eArbWait,
    eArbResp
  } arb_state_e;

endpackage

// File: rtl/sm4_rr_picker.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
module sm4_rr_picker #(
  parameter int num_req_p = 4
) (
  input  logic [num_req_p-1:0]         i_req,
  input  logic [$clog2(num_req_p)-1:0] i_last,
  output logic                         o_found,
  output logic [num_req_p-1:0]         o_grant,
  output logic [$clog2(num_req_p)-1:0] o_grant_id
);

  localparam int idx_w_lp = $clog2(num_req_p);

  int   w_idx;
  logic w_found;

  always_comb begin
    w_idx      = 0;
    w_found    = 1'b0;
    o_grant    = '0;
    o_grant_id = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      w_idx = (int'(i_last) + k) % num_req_p;
      if (!w_found && i_req[w_idx]) begin
        w_found           = 1'b1;
        o_grant[w_idx]    = 1'b1;
        o_grant_id        = w_idx[idx_w_lp-1:0];
      end
    end
    o_found = w_found;
  end

endmodule

// File: rtl/sm4_request_arbiter.sv
// Round-robin arbiter sharing one sm4_encryptor core among num_req_p requesters.
// Optional per-requester statistics are enabled with SM4_ARB_STATS_EN.
module sm4_request_arbiter
  import sm4_encryptor_pkg::*;
#(
  parameter int num_req_p      = 4,
  parameter int random_width_p = 32
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p*sm4_block_width_gp-1:0] req_content_i,
  input  logic [num_req_p*sm4_key_width_gp-1:0]   req_key_i,
  input  logic [num_req_p-1:0]                    req_decode_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  output logic [num_req_p-1:0]                    resp_v_o,
  output logic [sm4_block_width_gp-1:0]           resp_crypt_o,
  input  logic [num_req_p-1:0]                    resp_yumi_i,
  input  logic [random_width_p-1:0]               random_i,
  output logic [sm4_block_width_gp-1:0]           core_content_o,
  output logic [sm4_key_width_gp-1:0]             core_key_o,
  output logic [random_width_p-1:0]               core_random_o,
  output logic                                    core_encode_or_decode_o,
  output logic                                    core_v_o,
  input  logic                                    core_ready_i,
  input  logic [sm4_block_width_gp-1:0]           core_crypt_i,
  input  logic                                    core_v_i,
  output logic                                    core_yumi_o,
  output logic [$clog2(num_req_p)-1:0]            grant_id_o,
  output logic                                    busy_o
`ifdef SM4_ARB_STATS_EN
  ,
  output logic [num_req_p*sm4_stat_width_gp-1:0]  stat_grants_o,
  output logic [sm4_stat_width_gp-1:0]            stat_wait_max_o
`endif
);

  localparam int idx_w_lp = $clog2(num_req_p);
  localparam logic [idx_w_lp-1:0] last_init_lp = idx_w_lp'(num_req_p - 1);

  arb_state_e                    r_state;
  logic [idx_w_lp-1:0]           r_grant;
  logic [idx_w_lp-1:0]           r_rr_last;
  logic [sm4_block_width_gp-1:0] r_content;
  logic [sm4_key_width_gp-1:0]   r_key;
  logic                          r_decode;
  logic [sm4_block_width_gp-1:0] r_resp;

  logic                          w_pick_found;
  logic [num_req_p-1:0]          w_pick_grant;
  logic [idx_w_lp-1:0]           w_pick_id;
  logic [num_req_p-1:0]          w_grant_onehot;
  logic                          w_idle;

  sm4_rr_picker #(.num_req_p(num_req_p)) u_picker (
    .i_req      (req_v_i),
    .i_last     (r_rr_last),
    .o_found    (w_pick_found),
    .o_grant    (w_pick_grant),
    .o_grant_id (w_pick_id)
  );

  assign w_idle         = (r_state == eArbIdle);
  assign w_grant_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << r_grant;

  // Accept strobe is suppressed under reset so nothing is handed over that the reset would drop.
  assign req_ready_o             = (w_idle && !reset_i) ? w_pick_grant : '0;
  assign core_v_o                = (r_state == eArbIssue);
  assign core_yumi_o             = (r_state == eArbWait) && core_v_i;
  assign resp_v_o                = (r_state == eArbResp) ? w_grant_onehot : '0;
  assign resp_crypt_o            = r_resp;
  assign core_content_o          = r_content;
  assign core_key_o              = r_key;
  assign core_encode_or_decode_o = r_decode;
  assign core_random_o           = random_i;
  assign grant_id_o              = r_grant;
  assign busy_o                  = !w_idle;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= eArbIdle;
      r_grant   <= '0;
      r_rr_last <= last_init_lp;
      r_content <= '0;
      r_key     <= '0;
      r_decode  <= 1'b0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        eArbIdle: begin
          if (w_pick_found) begin
            r_content <= req_content_i[w_pick_id*sm4_block_width_gp +: sm4_block_width_gp];
            r_key     <= req_key_i[w_pick_id*sm4_key_width_gp +: sm4_key_width_gp];
            r_decode  <= req_decode_i[w_pick_id];
            r_grant   <= w_pick_id;
            r_state   <= eArbIssue;
          end
        end
        eArbIssue: begin
          if (core_ready_i) r_state <= eArbWait;
        end
        eArbWait: begin
          if (core_v_i) begin
            r_resp  <= core_crypt_i;
            r_state <= eArbResp;
          end
        end
        eArbResp: begin
          // Only the granted requester can retire the response.
          if (resp_yumi_i[r_grant]) begin
            r_rr_last <= r_grant;
            r_state   <= eArbIdle;
          end
        end
        default: r_state <= eArbIdle;
      endcase
    end
  end

`ifdef SM4_ARB_STATS_EN
  localparam logic [sm4_stat_width_gp-1:0] stat_max_lp = '1;

  logic [sm4_stat_width_gp-1:0] r_wait_cnt;
  logic [sm4_stat_width_gp-1:0] r_wait_max;
  logic [sm4_stat_width_gp-1:0] w_wait_inc;

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_stat
      logic [sm4_stat_width_gp-1:0] r_grants;
      always_ff @(posedge clk_i) begin
        if (reset_i)
          r_grants <= '0;
        else if (req_ready_o[gi] && (r_grants != stat_max_lp))
          r_grants <= r_grants + 1'b1;
      end
      assign stat_grants_o[gi*sm4_stat_width_gp +: sm4_stat_width_gp] = r_grants;
    end
  endgenerate

  // Wait length counts every eArbWait cycle, including the one that sees core_v_i.
  assign w_wait_inc = (r_wait_cnt == stat_max_lp) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wait_cnt <= '0;
      r_wait_max <= '0;
    end else if (r_state == eArbWait) begin
      if (core_v_i) begin
        r_wait_cnt <= '0;
        if (w_wait_inc > r_wait_max) r_wait_max <= w_wait_inc;
      end else begin
        r_wait_cnt <= w_wait_inc;
      end
    end
  end

  assign stat_wait_max_o = r_wait_max;
`endif

endmodule
